// File: rtl/instr_cache.sv
// ============================================================================
// Module   : instr_cache
// Purpose  : Direct-mapped 8-line instruction cache, 16-byte blocks,
//            zero-cycle hit, read-only fill from instruction memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module instr_cache (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         READ,
    input  logic [31:0]  PC,
    output logic [31:0]  INSTRUCTION,
    output logic         BUSYWAIT,
    output logic         MEM_READ,
    output logic [5:0]   MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [2:0]   idx;
    logic [2:0]   tag;
    logic [1:0]   offset;
    logic         hit;
    logic [127:0] line;
    logic [31:0]  word;
    logic         busy;
    logic         fetching;

    logic [7:0]   valid;
    logic [2:0]   tag_array  [8];
    logic [127:0] data_array [8];

    logic [2:0]   fill_idx;
    logic [2:0]   fill_tag;
    logic [127:0] fill_block;

    // Byte-offset and above-1023 bits carry no meaning for this cache.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{PC[31:10], PC[1:0]};

    assign idx    = PC[6:4];
    assign tag    = PC[9:7];
    assign offset = PC[3:2];

    assign hit  = READ & valid[idx] & (tag_array[idx] == tag);
    assign line = data_array[idx];

    always_comb begin
        word = 32'h0;
        case (offset)
            2'd0: word = line[31:0];
            2'd1: word = line[63:32];
            2'd2: word = line[95:64];
            2'd3: word = line[127:96];
            default: word = 32'h0;
        endcase
    end

    assign INSTRUCTION = hit ? word : 32'h0;

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        fetching   = 1'b0;
        case (state)
            IDLE: begin
                busy = READ & ~hit;
                if (READ & ~hit) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                busy     = 1'b1;
                fetching = 1'b1;
                if (!MEM_BUSYWAIT) begin
                    state_next = UPDATE;
                end
            end
            UPDATE: begin
                busy       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Gate with reset so the stall drops the instant reset is asserted,
    // even while the CPU still holds READ high on a now-invalid line.
    assign BUSYWAIT    = busy & RESET;
    assign MEM_READ    = fetching & RESET;
    assign MEM_ADDRESS = {fill_tag, fill_idx};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state <= IDLE;
            valid <= 8'h00;
        end else begin
            state <= state_next;
            if (state == UPDATE) begin
                valid[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data storage needs no reset: valid masks stale contents.
    always_ff @(posedge CLK) begin
        if (state == IDLE) begin
            fill_idx <= idx;
            fill_tag <= tag;
        end
        if (state == FETCH && !MEM_BUSYWAIT) begin
            fill_block <= MEM_READDATA;
        end
        if (state == UPDATE) begin
            tag_array[fill_idx]  <= fill_tag;
            data_array[fill_idx] <= fill_block;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_cache.sv
// ============================================================================
// Module   : tb_instr_cache
// Purpose  : Directed self-checking bench for instr_cache.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_instr_cache;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic         READ = 1'b0;
    logic [31:0]  PC = 32'h0;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         MEM_READ;
    logic [5:0]   MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT = 1'b0;

    int total = 0;
    int bad   = 0;
    int mem_lat = 1;
    int mem_cnt = 0;

    instr_cache dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .READ         (READ),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Unique, recognisable content for every word of every block.
    function automatic logic [31:0] mword(input logic [5:0] blk, input logic [1:0] w);
        return {16'hC0DE, 2'b00, blk, 6'b000000, w};
    endfunction

    assign MEM_READDATA = {mword(MEM_ADDRESS, 2'd3), mword(MEM_ADDRESS, 2'd2),
                           mword(MEM_ADDRESS, 2'd1), mword(MEM_ADDRESS, 2'd0)};

    // Memory answers on the mem_lat-th FETCH cycle.
    always @(negedge CLK) begin
        if (MEM_READ) mem_cnt = mem_cnt + 1;
        else          mem_cnt = 0;
        MEM_BUSYWAIT = MEM_READ && (mem_cnt < mem_lat);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic access(input logic [31:0] pc, input int lat, input bit miss, input string tag);
        int cycles;
        int fetches;
        logic addr_ok;
        mem_lat = lat;
        PC      = pc;
        READ    = 1'b1;
        #1;
        cycles  = 0;
        fetches = 0;
        addr_ok = 1'b1;
        while (BUSYWAIT && cycles < 60) begin
            if (MEM_READ) begin
                fetches++;
                if (MEM_ADDRESS !== pc[9:4]) addr_ok = 1'b0;
            end
            @(negedge CLK);
            #1;
            cycles++;
        end
        check({tag, ".stall"}, cycles, miss ? lat + 2 : 0);
        check({tag, ".fetch"}, fetches, miss ? lat : 0);
        if (miss) check({tag, ".addr"}, {31'd0, addr_ok}, 32'd1);
        check({tag, ".instr"}, INSTRUCTION, mword(pc[9:4], pc[3:2]));
        check({tag, ".memrd"}, {31'd0, MEM_READ}, 32'd0);
        @(negedge CLK);
        #1;
    endtask

    initial begin
        READ = 1'b1;
        PC   = 32'h0;
        repeat (2) @(negedge CLK);
        #1;
        check("rst.busy",  {31'd0, BUSYWAIT}, 32'd0);
        check("rst.memrd", {31'd0, MEM_READ}, 32'd0);
        check("rst.instr", INSTRUCTION, 32'h0);
        RESET = 1'b1;
        READ  = 1'b0;
        @(negedge CLK);
        #1;
        check("idle.busy", {31'd0, BUSYWAIT}, 32'd0);

        // Cold miss, then sequential hits in the same block.
        access(32'h000, 5, 1'b1, "pc000");
        access(32'h004, 5, 1'b0, "pc004");
        access(32'h008, 5, 1'b0, "pc008");
        access(32'h00C, 5, 1'b0, "pc00c");
        access(32'h005, 5, 1'b0, "pc005");
        access(32'h400, 5, 1'b0, "alias400");

        // Same index, different tag evicts the line both ways.
        access(32'h010, 3, 1'b1, "pc010");
        access(32'h090, 3, 1'b1, "pc090");
        access(32'h010, 3, 1'b1, "pc010b");
        access(32'h000, 3, 1'b0, "pc000b");

        // Zero-latency memory.
        access(32'h3FC, 1, 1'b1, "pc3fc");

        // Reset in the 3rd FETCH cycle aborts the fill.
        mem_lat = 10;
        PC      = 32'h020;
        READ    = 1'b1;
        repeat (3) @(negedge CLK);
        #1;
        check("abort.infetch", {31'd0, MEM_READ}, 32'd1);
        RESET = 1'b0;
        #1;
        check("abort.memrd", {31'd0, MEM_READ}, 32'd0);
        check("abort.busy",  {31'd0, BUSYWAIT}, 32'd0);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        access(32'h020, 4, 1'b1, "pc020");
        access(32'h000, 2, 1'b1, "pc000c");

        READ = 1'b0;
        @(negedge CLK);
        #1;
        check("noread.busy",  {31'd0, BUSYWAIT}, 32'd0);
        check("noread.memrd", {31'd0, MEM_READ}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/instr_cache.md
INSTR_CACHE -- requirements
Module: instr_cache

Interface
REQ-001 The module SHALL have a single clock and an asynchronous active-low reset: CLK in, RESET in (asynchronous, active-low), matching the clock/reset naming of the CPU's synchronous blocks.
REQ-002 CLK  input  1  rising-edge clock shared with the CPU.
REQ-003 RESET  input  1  asynchronous, active-low; 0 clears the cache.
REQ-004 READ  input  1  CPU fetch request; 1 means PC is valid this cycle.
REQ-005 PC  input  32  fetch byte address; only PC[9:2] is used, other bits are ignored.
REQ-006 INSTRUCTION  output  32  fetched instruction word, valid when READ=1 and BUSYWAIT=0.
REQ-007 BUSYWAIT  output  1  CPU stall; 1 means the CPU SHALL hold PC and not advance.
REQ-008 MEM_READ  output  1  block read request to instruction memory.
REQ-009 MEM_ADDRESS  output  6  block address {tag,index} = PC[9:4].
REQ-010 MEM_READDATA  input  128  16-byte block; word w is at bits [32w+31:32w].
REQ-011 MEM_BUSYWAIT  input  1  memory busy; data is valid in the cycle it returns to 0 while MEM_READ=1.

Function
REQ-012 The cache SHALL be direct-mapped: 8 lines, each holding 1 valid bit, a 3-bit tag and a 128-bit block.
REQ-013 Address split: word offset = PC[3:2], index = PC[6:4], tag = PC[9:7].
REQ-014 hit = READ & valid[index] & (tag_array[index] == PC[9:7]), evaluated combinationally from the current PC.
REQ-015 On a hit, INSTRUCTION SHALL be word PC[3:2] of the indexed block in the same cycle, with BUSYWAIT=0 (zero-cycle hit).
REQ-016 FSM states SHALL be IDLE, FETCH and UPDATE.
REQ-017 IDLE: BUSYWAIT = READ & ~hit and MEM_READ=0; on a clock edge with READ & ~hit, the FSM SHALL go to FETCH.
REQ-018 FETCH: MEM_READ=1, MEM_ADDRESS=PC[9:4], BUSYWAIT=1; the FSM SHALL stay while MEM_BUSYWAIT=1 and go to UPDATE on the first edge with MEM_BUSYWAIT=0.
REQ-019 The block SHALL be captured from MEM_READDATA at the FETCH->UPDATE edge.
REQ-020 UPDATE: MEM_READ=0, BUSYWAIT=1; on its edge the captured block, the tag and valid=1 SHALL be written to the line at index, and the FSM SHALL return to IDLE.
REQ-021 The cycle after UPDATE SHALL be a hit for the same PC (BUSYWAIT=0); miss penalty = memory latency + 2 cycles.
REQ-022 A miss SHALL replace the indexed line unconditionally (instruction lines are never dirty; no write-back).
REQ-023 PC SHALL be held stable by the CPU while BUSYWAIT=1; the cache SHALL NOT re-sample the index or tag during FETCH or UPDATE.
REQ-024 READ=0 in IDLE SHALL keep BUSYWAIT=0 and MEM_READ=0; INSTRUCTION is don't-care.
REQ-025 PC[1:0] != 0 SHALL be treated as PC with [1:0]=00.
REQ-026 PC wrap-around above 1023 SHALL alias to PC[9:0] with no error indication.
REQ-027 MEM_BUSYWAIT=0 on the first FETCH cycle (zero-latency memory) SHALL be legal: the FSM goes to UPDATE after one FETCH cycle.
REQ-028 The cache SHALL have no write path from the CPU; instruction memory is read-only.

Reset
REQ-029 RESET=0 SHALL immediately (asynchronously) clear all 8 valid bits, force state=IDLE and drive MEM_READ=0, BUSYWAIT=0 and INSTRUCTION=32'h0.
REQ-030 RESET asserted during FETCH or UPDATE SHALL abort the fill; no line is written and memory data arriving later is ignored.
REQ-031 The tag and data arrays SHALL need no reset; valid=0 masks them.
REQ-032 After RESET rises, the first fetch at any PC SHALL miss.

Verification
REQ-033 Reset, then READ=1, PC=0x000, memory latency 5 -> BUSYWAIT=1 immediately, MEM_READ=1 with MEM_ADDRESS=0 for 5 cycles, then UPDATE, then INSTRUCTION=MEM_READDATA[31:0] with BUSYWAIT=0 at cycle 7.
REQ-034 Following REQ-033, PC=0x004, 0x008, 0x00C -> hits with BUSYWAIT=0 every cycle, returning words 1, 2, 3 of the block; MEM_READ stays 0.
REQ-035 Conflict: fill PC=0x010, then PC=0x090 (same index 1, tag 1) -> miss with MEM_ADDRESS=0x09; then PC=0x010 -> miss again with MEM_ADDRESS=0x01.
REQ-036 Assert RESET=0 on the 3rd FETCH cycle of PC=0x020 -> MEM_READ=0 and BUSYWAIT=0 asynchronously; after release, PC=0x020 misses again.
REQ-037 Zero-latency memory (MEM_BUSYWAIT held 0), PC=0x3FC -> exactly 1 FETCH cycle and 1 UPDATE cycle, then a hit returning word 3 of block 0x3F.
REQ-038 PC=0x400 after PC=0x000 has been filled -> hit returning the same word as PC=0x000 (alias).
